// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller.
// Holds the stall-vector encodings, FSM state type, reset/zero constants and the
// default redirect values used by pipe_ctrl.
package pipe_ctrl_pkg;

  localparam logic        RstEnable = 1'b1;
  localparam logic [31:0] ZeroWord  = 32'h0000_0000;

  // Stall vector bit order: [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB, 1 = hold.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0020;
  localparam logic [31:0] ERET_CODE_DEFAULT  = 32'h0000_000e;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StPend  = 2'd1,
    StGuard = 2'd2
  } state_e;

  // Deepest requester wins: holding a later stage must also hold every earlier one.
  function automatic logic [5:0] stall_vec(input logic req_if, input logic req_id,
                                           input logic req_ex, input logic req_mem);
    if (req_mem)     return STALL_MEM;
    else if (req_ex) return STALL_EX;
    else if (req_id) return STALL_ID;
    else if (req_if) return STALL_IF;
    else             return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Stage-control bundle between the pipeline stages and pipe_ctrl.
// Requests/exception info flow into the controller; stall vector, flush and
// redirect PC flow back out.
//   master: controller side (drives stall_o, flush_o, new_pc_o)
//   slave : pipeline side  (drives stall requests and exception info)
interface pipe_ctrl_if;
  logic        stallreq_if_i;
  logic        stallreq_id_i;
  logic        stallreq_ex_i;
  logic        stallreq_mem_i;
  logic        exc_req_i;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;

  modport master (
    input  stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
    input  exc_req_i, excepttype_i, cp0_epc_i,
    output stall_o, flush_o, new_pc_o
  );

  modport slave (
    output stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
    output exc_req_i, excepttype_i, cp0_epc_i,
    input  stall_o, flush_o, new_pc_o
  );
endinterface

// File: rtl/pipe_ctrl_stall_watchdog.sv
// Stall watchdog: counts consecutive cycles with the PC held and raises a sticky
// timeout once the run reaches Limit.
//   clk, rst  : core clock, async active-high reset
//   stall_pc  : stall vector bit 0 (PC held this cycle)
//   timeout   : sticky flag, cleared only by rst
module pipe_ctrl_stall_watchdog
  import pipe_ctrl_pkg::*;
#(
  parameter logic [15:0] Limit = 16'd1023
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_pc,
  output logic timeout
);

  logic [15:0] run_q, run_d;
  logic        timeout_q, timeout_d;

  always_comb begin
    run_d     = 16'd0;
    timeout_d = timeout_q;
    if (stall_pc) begin
      // Saturate so a very long stall cannot wrap and look like a fresh run.
      run_d = (run_q == Limit) ? run_q : run_q + 16'd1;
      if (run_d == Limit) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      run_q     <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      run_q     <= run_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller for the 5-stage core.
// Merges stage stall requests into one stall vector, sequences exception/ERET
// flushes (deferring them while MEM is waiting), and keeps stall/flush counters
// plus a stall watchdog.
//   clk, rst        : core clock, async active-high reset
//   bus (master)    : stall requests, exception info in; stall_o/flush_o/new_pc_o out
//   stall_timeout_o : sticky watchdog flag
//   stall_cnt_o     : cycles with any stage stalled
//   flush_cnt_o     : flushes issued
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
  parameter logic [31:0] ERET_CODE  = ERET_CODE_DEFAULT,
  parameter logic [15:0] WDOG_LIMIT = 16'd1023,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipe_ctrl_if.master      bus,
  output logic             stall_timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  state_e      state_q, state_d;
  logic [31:0] type_q, type_d;
  logic [31:0] take_type;
  logic [5:0]  req_vec;
  logic [5:0]  stall;
  logic        flush;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    take_type = bus.excepttype_i;
    flush     = 1'b0;
    req_vec   = stall_vec(bus.stallreq_if_i, bus.stallreq_id_i,
                          bus.stallreq_ex_i, bus.stallreq_mem_i);

    unique case (state_q)
      StRun: begin
        if (bus.exc_req_i) begin
          if (bus.stallreq_mem_i) begin
            // MEM is still waiting on data; hold the exception until it finishes.
            type_d  = bus.excepttype_i;
            state_d = StPend;
          end else begin
            flush   = 1'b1;
            state_d = StGuard;
          end
        end
      end
      StPend: begin
        if (!bus.stallreq_mem_i) begin
          flush     = 1'b1;
          take_type = type_q;
          state_d   = StGuard;
        end
      end
      // Guard cycle: the exception request comes from a just-cleared register.
      default: state_d = StRun;
    endcase

    // Outputs are forced quiet during reset so nothing leaks while rst is high.
    if (rst == RstEnable) flush = 1'b0;
    stall = (flush || rst == RstEnable) ? STALL_NONE : req_vec;
  end

  assign bus.stall_o  = stall;
  assign bus.flush_o  = flush;
  assign bus.new_pc_o = !flush ? ZeroWord :
                        (take_type == ERET_CODE) ? bus.cp0_epc_i : EXC_VECTOR;

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state_q     <= StRun;
      type_q      <= ZeroWord;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      if (stall != STALL_NONE) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush)               flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

  pipe_ctrl_stall_watchdog #(
    .Limit (WDOG_LIMIT)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .stall_pc (stall[0]),
    .timeout  (stall_timeout_o)
  );

endmodule
